// File: rtl/source_fsm_pkg.sv
// Shared types for source_fsm: Gray-coded ring states and the {a,b} command codes.
package source_fsm_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b11,
    S3 = 2'b10
  } state_t;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_FWD  = 2'b01;
  localparam logic [1:0] CMD_BACK = 2'b10;
  localparam logic [1:0] CMD_CLR  = 2'b11;

endpackage

// File: rtl/source_fsm.sv
// Gray-coded up/down position tracker; y is the registered state code.
// Build option SOURCE_FSM_SATURATE_EN: stop at S3/S0 instead of wrapping around the ring.
module source_fsm
  import source_fsm_pkg::*;
#(
  parameter logic [1:0] RESET_STATE = 2'b00
) (
  output logic [1:0] y,
  input  logic       a,
  input  logic       b,
  input  logic       clk,
  input  logic       rst
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] cmd;

  assign cmd = {a, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S0: begin
        case (cmd)
          CMD_FWD:  state_d = S1;
`ifdef SOURCE_FSM_SATURATE_EN
          CMD_BACK: state_d = S0;
`else
          CMD_BACK: state_d = S3;
`endif
          CMD_CLR:  state_d = S0;
          default:  state_d = state_q;
        endcase
      end
      S1: begin
        case (cmd)
          CMD_FWD:  state_d = S2;
          CMD_BACK: state_d = S0;
          CMD_CLR:  state_d = S0;
          default:  state_d = state_q;
        endcase
      end
      S2: begin
        case (cmd)
          CMD_FWD:  state_d = S3;
          CMD_BACK: state_d = S1;
          CMD_CLR:  state_d = S0;
          default:  state_d = state_q;
        endcase
      end
      S3: begin
        case (cmd)
`ifdef SOURCE_FSM_SATURATE_EN
          CMD_FWD:  state_d = S3;
`else
          CMD_FWD:  state_d = S0;
`endif
          CMD_BACK: state_d = S2;
          CMD_CLR:  state_d = S0;
          default:  state_d = state_q;
        endcase
      end
      default: state_d = S0;
    endcase
  end

  always_comb begin
    y = state_q;
  end

endmodule

// File: tb/tb_source_fsm.sv
// Directed vector table plus random stream against a position-index model for source_fsm.
// Expectations follow the SOURCE_FSM_SATURATE_EN build setting.
module tb_source_fsm;

`ifdef SOURCE_FSM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       a;
    logic       b;
    logic [1:0] exp_y;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a   = 1'b0;
  logic       b   = 1'b0;
  logic [1:0] y;

  int unsigned checks = 0;
  int unsigned errors = 0;

  vec_t vecs[$];
  logic [1:0] gray [4];

  source_fsm #(.RESET_STATE(2'b00)) dut (
    .y  (y),
    .a  (a),
    .b  (b),
    .clk(clk),
    .rst(rst)
  );

  always #20 clk = ~clk;

  function automatic void add(logic r, logic ia, logic ib, logic [1:0] e, string n);
    vec_t v;
    v.rst = r; v.a = ia; v.b = ib; v.exp_y = e; v.name = n;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [1:0] got, logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: y=%b expected %b", name, got, exp);
    end
  endtask

  // Drive away from the edge, then sample 1 ns after the rising edge.
  task automatic step(logic r, logic ia, logic ib);
    @(negedge clk);
    rst = r; a = ia; b = ib;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pos;
    logic r, ia, ib;

    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;

    add(1, 0, 0, 2'b00, "reset");
    add(1, 1, 0, 2'b00, "reset_hold1");
    add(1, 1, 0, 2'b00, "reset_hold2");
    add(0, 0, 1, 2'b01, "fwd1");
    add(0, 0, 1, 2'b11, "fwd2");
    add(0, 0, 1, 2'b10, "fwd3");
    add(0, 0, 1, SAT ? 2'b10 : 2'b00, "fwd_wrap");
    add(0, 1, 1, 2'b00, "clr_from_top");
    add(0, 1, 0, SAT ? 2'b00 : 2'b10, "back1");
    add(0, 1, 0, SAT ? 2'b00 : 2'b11, "back2");
    add(0, 1, 1, 2'b00, "clr_after_back");
    add(0, 0, 1, 2'b01, "to_s1");
    add(0, 0, 1, 2'b11, "to_s2");
    add(0, 0, 0, 2'b11, "hold1");
    add(0, 0, 0, 2'b11, "hold2");
    add(0, 0, 0, 2'b11, "hold3");
    add(0, 1, 1, 2'b00, "clr_s2");
    add(0, 0, 1, 2'b01, "run1");
    add(0, 0, 1, 2'b11, "run2");
    add(0, 0, 1, 2'b10, "run3");
    add(1, 0, 1, 2'b00, "rst_mid");
    add(0, 0, 1, 2'b01, "resume");
    add(0, 1, 0, 2'b00, "back_to_s0");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].a, vecs[i].b);
      check(vecs[i].name, y, vecs[i].exp_y);
    end

    // No combinational path: y must not move between input change and the edge.
    @(negedge clk);
    rst = 0; a = 0; b = 1;
    #5;
    check("no_comb_path", y, 2'b00);
    @(posedge clk);
    #1;
    check("latency_one_clk", y, 2'b01);

    // Random stream, model tracks ring position 0..3.
    step(1, 0, 0);
    check("rand_reset", y, 2'b00);
    pos = 0;
    for (int n = 0; n < 32; n++) begin
      r  = ($urandom_range(0, 15) == 0);
      ia = 1'($urandom_range(0, 1));
      ib = 1'($urandom_range(0, 1));
      step(r, ia, ib);
      if (r) begin
        pos = 0;
      end else begin
        case ({ia, ib})
          2'b01: pos = (pos == 3) ? (SAT ? 3 : 0) : pos + 1;
          2'b10: pos = (pos == 0) ? (SAT ? 0 : 3) : pos - 1;
          2'b11: pos = 0;
          default: ;
        endcase
      end
      check("random", y, gray[pos]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
